// File: rtl/posit_defines.sv
// Shared posit definitions: the 32-bit ES=2 posit width and the packed
// product record that the result FIFO carries.
package posit_defines;

  localparam int NBITS             = 32;
  localparam int RESULT_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [NBITS-1:0] bits;
    logic             inf;
    logic             zero;
  } posit_result_t;

endpackage

// File: rtl/posit_result_ram.sv
// Register-array storage for the result FIFO: one synchronous write port
// and one asynchronous read port, so the head entry is visible immediately.
module posit_result_ram
  import posit_defines::*;
#(
  parameter int DEPTH = RESULT_FIFO_DEPTH,
  parameter int WIDTH = $bits(posit_result_t),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: contents are only meaningful once pushed, so no reset.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/posit_result_fifo.sv
// First-word-fall-through buffer for multiplier products with NaR/zero
// statistics and a sticky overflow flag for pushes dropped while full.
module posit_result_fifo
  import posit_defines::*;
#(
  parameter int NBITS_P = NBITS,
  parameter int DEPTH   = RESULT_FIFO_DEPTH,
  parameter int CNTW    = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NBITS_P-1:0] in_result,
  input  logic               in_inf,
  input  logic               in_zero,
  input  logic               in_done,
  output logic [NBITS_P-1:0] out_result,
  output logic               out_inf,
  output logic               out_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic [CNTW-1:0]    drop_count,
  output logic [CNTW-1:0]    nar_count,
  output logic [CNTW-1:0]    zero_count
);

  localparam int                WIDTH     = NBITS_P + 2;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);
  localparam logic [CNTW-1:0]   CNT_MAX   = '1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [CNTW-1:0]  r_drop_count;
  logic [CNTW-1:0]  r_nar_count;
  logic [CNTW-1:0]  r_zero_count;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata;

  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~w_empty & out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign w_push_ok = in_done & (~w_full | w_pop);
  assign w_drop    = in_done & w_full & ~w_pop;
  // Reset wins over a concurrent push so nothing lands in storage.
  assign w_we      = w_push_ok & ~reset;
  assign w_wdata   = {in_result, in_inf, in_zero};

  posit_result_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push_ok) r_count <= r_count - CW'(1);
    end
  end

  // Overflow flag and saturating drop/NaR/zero statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_nar_count  <= '0;
      r_zero_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != CNT_MAX) r_drop_count <= r_drop_count + CNTW'(1);
      end
      if (w_push_ok) begin
        // NaR takes precedence when both flags are raised.
        if (in_inf) begin
          if (r_nar_count != CNT_MAX) r_nar_count <= r_nar_count + CNTW'(1);
        end else if (in_zero) begin
          if (r_zero_count != CNT_MAX) r_zero_count <= r_zero_count + CNTW'(1);
        end
      end
    end
  end

  assign out_result = w_rdata[WIDTH-1:2];
  assign out_inf    = w_rdata[1];
  assign out_zero   = w_rdata[0];
  assign out_valid  = ~w_empty;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign nar_count  = r_nar_count;
  assign zero_count = r_zero_count;

endmodule

// File: tb/tb_posit_result_fifo.sv
// Self-checking bench for posit_result_fifo: a queue scoreboard plus a
// small occupancy/statistics model checked every cycle, with directed
// checks at the scenario boundaries.
module tb_posit_result_fifo;
  import posit_defines::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_result;
  logic        in_inf;
  logic        in_zero;
  logic        in_done;
  logic [31:0] out_result;
  logic        out_inf;
  logic        out_zero;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] nar_count;
  logic [15:0] zero_count;

  int total = 0;
  int bad   = 0;

  posit_result_t m_q[$];
  logic          m_ovf;
  logic [15:0]   m_drop;
  logic [15:0]   m_nar;
  logic [15:0]   m_zero;

  posit_result_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .in_result  (in_result),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .in_done    (in_done),
    .out_result (out_result),
    .out_inf    (out_inf),
    .out_zero   (out_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .nar_count  (nar_count),
    .zero_count (zero_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("head_result", 64'(out_result), 64'(m_q[0].bits));
      chk("head_inf",    64'(out_inf),    64'(m_q[0].inf));
      chk("head_zero",   64'(out_zero),   64'(m_q[0].zero));
    end
    chk("count",      64'(count),      64'(m_q.size()));
    chk("full",       64'(full),       64'(m_q.size() == DEPTH));
    chk("empty",      64'(empty),      64'(m_q.size() == 0));
    chk("overflow",   64'(overflow),   64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("nar_count",  64'(nar_count),  64'(m_nar));
    chk("zero_count", 64'(zero_count), 64'(m_zero));
  endtask

  // One clock cycle: drive inputs at negedge, check state, advance model.
  task automatic step(input logic d, input logic [31:0] r, input logic fi,
                      input logic fz, input logic rdy);
    logic          pop, is_full, push_ok, drop;
    posit_result_t e;
    @(negedge clk);
    reset = 1'b0; in_done = d; in_result = r; in_inf = fi; in_zero = fz; out_ready = rdy;
    check_state();
    is_full = (m_q.size() == DEPTH);
    pop     = (m_q.size() != 0) && rdy;
    push_ok = d && (!is_full || pop);
    drop    = d && is_full && !pop;
    if (pop) e = m_q.pop_front();
    if (push_ok) begin
      e.bits = r; e.inf = fi; e.zero = fz;
      m_q.push_back(e);
      if (fi) begin
        if (m_nar != 16'hFFFF) m_nar++;
      end else if (fz) begin
        if (m_zero != 16'hFFFF) m_zero++;
      end
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic d, input logic [31:0] r);
    @(negedge clk);
    reset = 1'b1; in_done = d; in_result = r; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_q.delete();
    m_ovf = 1'b0; m_drop = '0; m_nar = '0; m_zero = '0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    reset = 1'b1; in_done = 1'b0; in_result = '0; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b0;
    m_ovf = 1'b0; m_drop = '0; m_nar = '0; m_zero = '0;
    do_reset(1'b0, 32'h0);

    // Reset state.
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_empty", 64'(empty),     64'd1);
    chk("rst_full",  64'(full),      64'd0);
    chk("rst_count", 64'(count),     64'd0);

    // 1: single push, held, then popped.
    step(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    chk("t1_valid",  64'(out_valid),  64'd1);
    chk("t1_result", 64'(out_result), 64'h4000_0000);
    chk("t1_count",  64'(count),      64'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_empty",  64'(empty), 64'd1);
    chk("t1_count0", 64'(count), 64'd0);

    // 2: three pushes, consumer ready from the fourth cycle.
    step(1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4800_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    chk("t2_head", 64'(out_result), 64'h4000_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_second", 64'(out_result), 64'h4800_0000);
    idle(3, 1'b1);
    chk("t2_drained", 64'(out_valid), 64'd0);

    // 3: nine pushes into an eight-deep FIFO, consumer stalled.
    for (int i = 0; i < 9; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("t3_full",  64'(full),       64'd1);
    chk("t3_ovf",   64'(overflow),   64'd1);
    chk("t3_drops", 64'(drop_count), 64'd1);
    chk("t3_head",  64'(out_result), 64'h1000_0000);
    idle(9, 1'b1);

    // 4: full FIFO with simultaneous push and pop.
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2BAD_0001, 1'b0, 1'b0, 1'b1);
    chk("t4_count", 64'(count),    64'd8);
    chk("t4_ovf",   64'(overflow), 64'd0);
    chk("t4_head",  64'(out_result), 64'h2000_0001);
    idle(9, 1'b1);

    // 5: NaR and zero statistics, including both flags set.
    step(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    chk("t5_nar",  64'(nar_count),  64'd2);
    chk("t5_zero", 64'(zero_count), 64'd1);
    idle(4, 1'b1);

    // Random mixed traffic against the scoreboard.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    idle(10, 1'b1);

    // 6: five entries with overflow set, reset with concurrent push.
    for (int i = 0; i < 9; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("t6_pre_count", 64'(count),    64'd5);
    chk("t6_pre_ovf",   64'(overflow), 64'd1);
    do_reset(1'b1, 32'h3FFF_FFFF);
    chk("t6_count", 64'(count),      64'd0);
    chk("t6_empty", 64'(empty),      64'd1);
    chk("t6_ovf",   64'(overflow),   64'd0);
    chk("t6_drop",  64'(drop_count), 64'd0);
    chk("t6_nar",   64'(nar_count),  64'd0);
    chk("t6_zero",  64'(zero_count), 64'd0);
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_result_fifo.md
Name: posit_result_fifo

Overview:
Buffers products from the ES=2, 32-bit posit multiplier. Each cycle the multiplier raises done, the block captures {result, inf, zero} into a DEPTH-entry first-word-fall-through FIFO. It presents the oldest entry to the downstream consumer (adder/accumulator stage) over a valid/ready handshake. It also keeps running counts of NaR (inf) and zero products, plus a sticky overflow flag for products dropped while full.

Parameters:
NBITS, 32, posit width (from posit_defines)
DEPTH, 8, FIFO entries; power of two, minimum 2
CNTW, 16, width of the statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_result  in  NBITS  posit product from multiplier
in_inf  in  1  product is NaR
in_zero  in  1  product is zero
in_done  in  1  push request; one product per cycle when high
out_result  out  NBITS  head entry posit
out_inf  out  1  head entry NaR flag
out_zero  out  1  head entry zero flag
out_valid  out  1  head entry valid (FIFO not empty)
out_ready  in  1  consumer accepts head this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a push was dropped
drop_count  out  CNTW  number of dropped pushes, saturating
nar_count  out  CNTW  accepted pushes with in_inf=1, saturating
zero_count  out  CNTW  accepted pushes with in_zero=1 and in_inf=0, saturating

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- reset=1 at an edge: count=0, rd/wr pointers=0, overflow=0, all counters=0. After reset, out_valid=0, empty=1, full=0. out_result/out_inf/out_zero are don't-care while out_valid=0; the bench must not check them then. Reset mid-stream discards all contents; a push or pop in the same cycle as reset is ignored.
- pop = out_valid & out_ready.
- push_ok = in_done & (~full | pop). A push to a full FIFO succeeds only if a pop happens in the same cycle.
- drop = in_done & full & ~pop. On drop: overflow<=1 (sticky until reset) and drop_count increments (saturating). No storage changes.
- Storage: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked explicitly.
  - push_ok only: write entry, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push_ok and pop together: both pointers advance, count unchanged. This also applies when count==1: the new entry becomes head on the next cycle.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (out_valid=1 in cycle N+1) if the FIFO was empty. There is no combinational in_* to out_* path.
- out_* are driven from storage[rd_ptr]. out_valid = ~empty, from the registered count.
- Ordering is strict FIFO. Entry fields are stored exactly as received, with no re-encoding.
- Statistics (on push_ok only):
  - nar_count++ if in_inf.
  - zero_count++ else if in_zero.
  - All counters stop at 2^CNTW-1.
- in_inf and in_zero both high: counted as NaR only. Both flags are stored unchanged.
- full, empty and count are registered-state derived and glitch-free.

Decomposition:
- posit_defines package:
  - add typedef posit_result_t, a packed struct {logic [NBITS-1:0] bits; logic inf; logic zero;}.
  - add localparam RESULT_FIFO_DEPTH = 8.
- One sub-module, posit_result_ram: a DEPTH x $bits(posit_result_t) register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count, handshake and statistics logic stays in posit_result_fifo.

Test Plan:
1. Reset, then single push in_result=0x40000000 (1.0) with in_done=1 for 1 cycle, out_ready=0 → next cycle out_valid=1, out_result=0x40000000, count=1. Raise out_ready for 1 cycle → empty=1, count=0.
2. Push 0x40000000, 0x48000000, 0xC0000000 on consecutive cycles, out_ready=1 from cycle 4 → outputs appear in the same order, each for exactly one cycle, then out_valid=0.
3. Push 9 products back-to-back with DEPTH=8 and out_ready=0 → full=1 after 8, the 9th is dropped, overflow=1, drop_count=1. Head is still the first product.
4. FIFO full, in_done=1 and out_ready=1 in the same cycle → no drop, count stays 8, the new entry lands at the tail, overflow stays 0.
5. Push {0x80000000, inf=1}, {0x00000000, zero=1}, {0x00000000, inf=1, zero=1} → nar_count=2, zero_count=1.
6. FIFO holding 5 entries with overflow=1, assert reset for 1 cycle while in_done=1 → count=0, empty=1, overflow=0, all counters 0, and the concurrent push is not stored.
